apb_reg_slave: RTL and testbench

// - APB completer (slave) holding a small word-addressed register bank at BASE_ADDR.
// - Target for the APB read-increment-write master in this design: it returns the stored word on a

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_slv_regfile.sv | 42 ++++
 rtl/apb_reg_slave.sv | 128 ++++++++++++
 tb/tb_apb_reg_slave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB widths and the completer FSM state type.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_READY
   } apb_slv_state_t;

endpackage

// File: rtl/apb_slv_regfile.sv
// Register bank: one synchronous write port, one combinational read port.
module apb_slv_regfile
   import apb_pkg::*;
#(
   parameter int unsigned          NUM_REGS  = 4,
   parameter int unsigned          IDX_W     = 2,
   parameter logic [APB_DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      widx_i,
   input  logic [APB_DATA_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]      ridx_i,
   output logic [APB_DATA_W-1:0] rdata_o
);

   logic [APB_DATA_W-1:0] regs_q [NUM_REGS];
   logic [APB_DATA_W-1:0] regs_d [NUM_REGS];

   always_comb begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         regs_d[i] = regs_q[i];
      end
      if (we_i) begin
         regs_d[widx_i] = wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (rst_i) begin
            regs_q[i] <= RESET_VAL;
         end else begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign rdata_o = regs_q[ridx_i];

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with a small word-addressed register bank, programmable wait
// states and an error response for out-of-range or misaligned addresses.
module apb_reg_slave
   import apb_pkg::*;
#(
   parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_A000,
   parameter int unsigned           NUM_REGS    = 4,
   parameter int unsigned           WAIT_CYCLES = 0,
   parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic [APB_ADDR_W-1:0] paddr_i,
   input  logic                  pwrite_i,
   input  logic [APB_DATA_W-1:0] pwdata_i,
   output logic [APB_DATA_W-1:0] prdata_o,
   output logic                  pready_o,
   output logic                  pslverr_o,
   output logic [7:0]            wr_count_o
);

   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [APB_ADDR_W-1:0] SPAN = APB_ADDR_W'(4 * NUM_REGS);

   apb_slv_state_t        state_q, state_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  hit_q, hit_d;
   logic                  pwrite_q, pwrite_d;
   logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
   logic [7:0]            wr_count_q, wr_count_d;

   logic [APB_ADDR_W-1:0] offset;
   logic                  hit;
   logic                  we;
   logic [APB_DATA_W-1:0] rdata;

   // Offset compare avoids overflow when the bank sits at the top of the map.
   assign offset = paddr_i - BASE_ADDR;
   assign hit    = (paddr_i[1:0] == 2'b00) && (paddr_i >= BASE_ADDR) && (offset < SPAN);

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      idx_d      = idx_q;
      hit_d      = hit_q;
      pwrite_d   = pwrite_q;
      pwdata_d   = pwdata_q;
      wr_count_d = wr_count_q;
      we         = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (psel_i && !penable_i) begin
               idx_d    = offset[IDX_W+1:2];
               hit_d    = hit;
               pwrite_d = pwrite_i;
               pwdata_d = pwdata_i;
               wcnt_d   = 4'(WAIT_CYCLES);
               state_d  = (WAIT_CYCLES > 0) ? ST_WAIT : ST_READY;
            end
         end
         ST_WAIT: begin
            if (!psel_i) begin
               state_d = ST_IDLE;
            end else if (penable_i) begin
               wcnt_d = wcnt_q - 4'd1;
               if (wcnt_q == 4'd1) begin
                  state_d = ST_READY;
               end
            end
         end
         ST_READY: begin
            if (!psel_i) begin
               state_d = ST_IDLE;
            end else if (penable_i) begin
               we = pwrite_q && hit_q;
               if (we) begin
                  wr_count_d = wr_count_q + 8'd1;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q    <= ST_IDLE;
         wcnt_q     <= '0;
         idx_q      <= '0;
         hit_q      <= 1'b0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         idx_q      <= idx_d;
         hit_q      <= hit_d;
         pwrite_q   <= pwrite_d;
         pwdata_q   <= pwdata_d;
         wr_count_q <= wr_count_d;
      end
   end

   apb_slv_regfile #(
      .NUM_REGS  (NUM_REGS),
      .IDX_W     (IDX_W),
      .RESET_VAL (RESET_VAL)
   ) u_regfile (
      .clk_i   (pclk),
      .rst_i   (preset),
      .we_i    (we),
      .widx_i  (idx_q),
      .wdata_i (pwdata_q),
      .ridx_i  (idx_q),
      .rdata_o (rdata)
   );

   assign pready_o   = (state_q == ST_READY);
   assign pslverr_o  = pready_o && !hit_q;
   assign prdata_o   = (pready_o && hit_q && !pwrite_q) ? rdata : '0;
   assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench: a zero-wait and a three-wait completer share the APB bus
// signals and are selected by their own psel.
module tb_apb_reg_slave;

   logic        pclk = 1'b0;
   logic        preset;
   logic        psel0, psel3, penable, pwrite;
   logic [31:0] paddr, pwdata;

   logic [31:0] prdata0, prdata3;
   logic        pready0, pready3, pslverr0, pslverr3;
   logic [7:0]  wr_count0, wr_count3;

   int          n_checks = 0;
   int          n_pass   = 0;

   logic [31:0] rd;
   logic        err;
   int          w;

   always #5 pclk = ~pclk;

   apb_reg_slave #(.WAIT_CYCLES(0)) u_dut0 (
      .pclk       (pclk),
      .preset     (preset),
      .psel_i     (psel0),
      .penable_i  (penable),
      .paddr_i    (paddr),
      .pwrite_i   (pwrite),
      .pwdata_i   (pwdata),
      .prdata_o   (prdata0),
      .pready_o   (pready0),
      .pslverr_o  (pslverr0),
      .wr_count_o (wr_count0)
   );

   apb_reg_slave #(.WAIT_CYCLES(3)) u_dut3 (
      .pclk       (pclk),
      .preset     (preset),
      .psel_i     (psel3),
      .penable_i  (penable),
      .paddr_i    (paddr),
      .pwrite_i   (pwrite),
      .pwdata_i   (pwdata),
      .prdata_o   (prdata3),
      .pready_o   (pready3),
      .pslverr_o  (pslverr3),
      .wr_count_o (wr_count3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Leaves psel/penable high at completion so a following call is back-to-back.
   task automatic xfer(input bit d3, input logic [31:0] addr, input bit wr,
                       input logic [31:0] wd, output logic [31:0] rdat,
                       output logic perr, output int waits);
      @(negedge pclk);
      psel0   = !d3;
      psel3   = d3;
      penable = 1'b0;
      paddr   = addr;
      pwrite  = wr;
      pwdata  = wd;
      @(negedge pclk);
      penable = 1'b1;
      waits   = 0;
      while (!(d3 ? pready3 : pready0) && waits < 20) begin
         waits++;
         @(negedge pclk);
      end
      if (waits >= 20) check("timeout", 32'(waits), 32'd0);
      rdat = d3 ? prdata3 : prdata0;
      perr = d3 ? pslverr3 : pslverr0;
   endtask

   task automatic idle();
      @(negedge pclk);
      psel0   = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      preset  = 1'b1;
      psel0   = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      repeat (2) @(negedge pclk);
      preset = 1'b0;
      @(negedge pclk);
      check("rst_pready", {31'd0, pready0}, 32'd0);
      check("rst_pslverr", {31'd0, pslverr0}, 32'd0);
      check("rst_prdata", prdata0, 32'd0);
      check("rst_wr_count", {24'd0, wr_count0}, 32'd0);

      // Access phase without setup must be ignored.
      psel0   = 1'b1;
      penable = 1'b1;
      paddr   = 32'hA000;
      @(negedge pclk);
      check("no_setup_pready", {31'd0, pready0}, 32'd0);
      idle();

      xfer(0, 32'hA000, 0, 32'h0, rd, err, w);
      check("rd0_data", rd, 32'd0);
      check("rd0_err", {31'd0, err}, 32'd0);
      check("rd0_waits", 32'(w), 32'd0);

      xfer(0, 32'hA004, 1, 32'h1234_5678, rd, err, w);
      check("wr4_err", {31'd0, err}, 32'd0);
      xfer(0, 32'hA004, 0, 32'h0, rd, err, w);
      check("rd4_data", rd, 32'h1234_5678);
      idle();
      check("wr4_count", {24'd0, wr_count0}, 32'd1);
      xfer(0, 32'hA000, 0, 32'h0, rd, err, w);
      check("rd0_still0", rd, 32'd0);
      xfer(0, 32'hA008, 0, 32'h0, rd, err, w);
      check("rd8_still0", rd, 32'd0);
      xfer(0, 32'hA00C, 0, 32'h0, rd, err, w);
      check("rdc_still0", rd, 32'd0);

      // Read-increment-write, all transfers back-to-back.
      for (int i = 0; i < 3; i++) begin
         xfer(0, 32'hA000, 0, 32'h0, rd, err, w);
         check("riw_rd", rd, 32'(i));
         check("riw_rd_waits", 32'(w), 32'd0);
         xfer(0, 32'hA000, 1, rd + 32'd1, rd, err, w);
         check("riw_wr_waits", 32'(w), 32'd0);
      end
      idle();
      check("riw_count", {24'd0, wr_count0}, 32'd4);
      xfer(0, 32'hA000, 0, 32'h0, rd, err, w);
      check("riw_final", rd, 32'd3);

      xfer(0, 32'hA010, 1, 32'hDEAD_BEEF, rd, err, w);
      check("oor_err", {31'd0, err}, 32'd1);
      idle();
      check("oor_count", {24'd0, wr_count0}, 32'd4);
      xfer(0, 32'hA000, 0, 32'h0, rd, err, w);
      check("oor_reg0", rd, 32'd3);
      check("ok_err", {31'd0, err}, 32'd0);
      xfer(0, 32'hA004, 0, 32'h0, rd, err, w);
      check("oor_reg1", rd, 32'h1234_5678);

      xfer(0, 32'hA002, 0, 32'h0, rd, err, w);
      check("mis_err", {31'd0, err}, 32'd1);
      check("mis_data", rd, 32'd0);
      idle();

      xfer(1, 32'hA008, 1, 32'hCAFE_F00D, rd, err, w);
      check("w3_wr_waits", 32'(w), 32'd3);
      check("w3_wr_err", {31'd0, err}, 32'd0);
      xfer(1, 32'hA008, 0, 32'h0, rd, err, w);
      check("w3_rd_waits", 32'(w), 32'd3);
      check("w3_rd_data", rd, 32'hCAFE_F00D);
      idle();
      check("w3_count", {24'd0, wr_count3}, 32'd1);

      // Abort: drop psel in the second access cycle of a write.
      @(negedge pclk);
      psel3   = 1'b1;
      penable = 1'b0;
      paddr   = 32'hA00C;
      pwrite  = 1'b1;
      pwdata  = 32'h0000_0055;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel3   = 1'b0;
      penable = 1'b0;
      @(negedge pclk);
      check("abort_pready", {31'd0, pready3}, 32'd0);
      check("abort_count", {24'd0, wr_count3}, 32'd1);
      xfer(1, 32'hA00C, 0, 32'h0, rd, err, w);
      check("abort_reg", rd, 32'd0);
      idle();

      // Reset while a write is waiting.
      @(negedge pclk);
      psel3   = 1'b1;
      penable = 1'b0;
      paddr   = 32'hA004;
      pwrite  = 1'b1;
      pwdata  = 32'h0000_0077;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      preset = 1'b1;
      @(negedge pclk);
      preset  = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
      check("mrst_pready", {31'd0, pready3}, 32'd0);
      check("mrst_count", {24'd0, wr_count3}, 32'd0);
      xfer(1, 32'hA008, 0, 32'h0, rd, err, w);
      check("mrst_reg2", rd, 32'd0);
      xfer(1, 32'hA004, 0, 32'h0, rd, err, w);
      check("mrst_reg1", rd, 32'd0);
      xfer(1, 32'hA000, 1, 32'h0000_0011, rd, err, w);
      check("post_wr_waits", 32'(w), 32'd3);
      xfer(1, 32'hA000, 0, 32'h0, rd, err, w);
      check("post_rd", rd, 32'h0000_0011);
      idle();
      check("post_count", {24'd0, wr_count3}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
